pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 16-bit five-stage core. It watches the instruction in ID and in EX, the EX branch decision, and the data-memory handshake. It drives the PC and pipeline-register write enables, flushes and the branch redirect select. It also owns boot hold, halt, memory-wait freeze with timeout, and two saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 16-bit five-stage core: boot hold, hazard stalls,
// branch redirect, memory-wait freeze with timeout, halt, and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter logic [3:0]  LOAD_OPC    = 4'b1000,
  parameter logic [3:0]  BR_LO       = 4'b1010,
  parameter logic [3:0]  BR_HI       = 4'b1100,
  parameter logic [3:0]  HALT_OPC    = 4'b1111,
  parameter int unsigned WAIT_MAX    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ins_id,
  input  logic        id_valid,
  input  logic [15:0] ins_ex,
  input  logic        ex_valid,
  input  logic        do_branch,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_flush,
  output logic        ex_mem_we,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned      BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;

  state_t            state, state_n;
  logic [BOOT_W-1:0] boot_cnt, boot_cnt_n;
  logic [7:0]        wait_cnt, wait_cnt_n;
  logic              stall_inc, flush_inc, timeout_set;

  logic [3:0] ex_opc, id_opc;
  logic [2:0] ex_dest;
  logic       freeze, is_halt, is_branch, rt_used, load_use;
  logic       unused_bits;

  assign ex_opc    = ins_ex[15:12];
  assign id_opc    = ins_id[15:12];
  assign ex_dest   = ins_ex[8:6];
  assign freeze    = mem_req & ~mem_ack;
  assign is_halt   = ex_valid && (ex_opc == HALT_OPC);
  assign is_branch = ex_valid && do_branch && (ex_opc >= BR_LO) && (ex_opc <= BR_HI);
  assign rt_used   = (id_opc == 4'b0000) || ((id_opc >= 4'b1001) && (id_opc <= 4'b1100));
  // r0 is never a real load destination, so it cannot create a hazard
  assign load_use  = ex_valid && id_valid && (ex_opc == LOAD_OPC) && (ex_dest != 3'd0) &&
                     ((ex_dest == ins_id[11:9]) || (rt_used && (ex_dest == ins_id[8:6])));
  assign unused_bits = ^{ins_id[5:0], ins_ex[11:9], ins_ex[5:0]};

  always_comb begin
    pc_we       = 1'b1;
    pc_sel      = 1'b0;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b1;
    halted      = 1'b0;
    state_n     = state;
    boot_cnt_n  = boot_cnt;
    wait_cnt_n  = wait_cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    timeout_set = 1'b0;

    case (state)
      BOOT: begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (boot_cnt == BOOT_LAST) state_n = RUN;
        else                       boot_cnt_n = boot_cnt + 1'b1;
      end
      HALT: begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        if (freeze) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
          stall_inc = 1'b1;
          if (state == RUN) begin
            state_n = MEM_WAIT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_set = 1'b1;
            state_n     = HALT;
          end else begin
            wait_cnt_n = wait_cnt + 8'd1;
          end
        end else begin
          // a resolved wait decodes the held instructions in the same cycle
          wait_cnt_n = '0;
          state_n    = RUN;
          if (is_halt) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            state_n     = HALT;
          end else if (is_branch) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_n;
      boot_cnt <= boot_cnt_n;
      wait_cnt <= wait_cnt_n;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned BOOT_CYCLES = 4;
  localparam int unsigned WAIT_MAX    = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins_id, ins_ex;
  logic        id_valid, ex_valid, do_branch, mem_req, mem_ack;
  logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
  logic        halted, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .WAIT_MAX   (WAIT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_id(ins_id), .id_valid(id_valid), .ins_ex(ins_ex), .ex_valid(ex_valid),
    .do_branch(do_branch), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode name plus plain integer counts
  string m_mode;
  int    m_boot, m_wait, m_stall, m_flush;
  bit    m_timeout;

  // {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}
  localparam logic [7:0] C_BOOT   = 8'b0001_1110;
  localparam logic [7:0] C_HALTED = 8'b0000_1111;
  localparam logic [7:0] C_HOLD   = 8'b0000_1110;
  localparam logic [7:0] C_BRANCH = 8'b1111_1110;
  localparam logic [7:0] C_NORMAL = 8'b1010_1010;
  localparam logic [7:0] C_FROZEN = 8'b0000_0000;

  function automatic int opc(input logic [15:0] i);
    return (int'(i) >> 12) & 15;
  endfunction

  function automatic bit m_halt_req();
    return ex_valid && opc(ins_ex) == 15;
  endfunction

  function automatic bit m_branch_taken();
    int o = opc(ins_ex);
    return ex_valid && do_branch && o >= 10 && o <= 12;
  endfunction

  function automatic bit m_hazard();
    int d, rs, rt, o;
    if (!ex_valid || !id_valid || opc(ins_ex) != 8) return 0;
    d  = (int'(ins_ex) >> 6) & 7;
    rs = (int'(ins_id) >> 9) & 7;
    rt = (int'(ins_id) >> 6) & 7;
    o  = opc(ins_id);
    if (d == 0) return 0;
    return d == rs || ((o == 0 || (o >= 9 && o <= 12)) && d == rt);
  endfunction

  function automatic bit m_frozen();
    return mem_req && !mem_ack;
  endfunction

  function automatic logic [7:0] exp_ctrl();
    if (!rst_n || m_mode == "BOOT") return C_BOOT;
    if (m_mode == "HALT")           return C_HALTED;
    if (m_frozen())                 return C_FROZEN;
    if (m_halt_req())               return C_HOLD;
    if (m_branch_taken())           return C_BRANCH;
    if (m_hazard())                 return C_HOLD;
    return C_NORMAL;
  endfunction

  function automatic logic [32:0] exp_stat();
    return {m_timeout, 16'(m_stall), 16'(m_flush)};
  endfunction

  task automatic model_reset();
    m_mode = "BOOT"; m_boot = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == "BOOT") begin
      m_boot++;
      if (m_boot == BOOT_CYCLES) m_mode = "RUN";
    end else if (m_mode == "RUN" || m_mode == "WAIT") begin
      if (m_frozen()) begin
        if (m_stall < 65535) m_stall++;
        if (m_mode == "RUN") begin
          m_mode = "WAIT";
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == WAIT_MAX) begin
            m_timeout = 1;
            m_mode = "HALT";
          end
        end
      end else begin
        m_wait = 0;
        m_mode = "RUN";
        if (m_halt_req())            m_mode = "HALT";
        else if (m_branch_taken()) begin if (m_flush < 65535) m_flush++; end
        else if (m_hazard())       begin if (m_stall < 65535) m_stall++; end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ins_id = '0; id_valid = 0; ins_ex = '0; ex_valid = 0;
    do_branch = 0; mem_req = 0; mem_ack = 0;
  endtask

  function automatic logic [15:0] rand_ins(input bit allow_halt);
    int r = $urandom_range(0, 9);
    logic [3:0] o;
    if (r <= 2)      o = 4'h8;
    else if (r <= 5) o = 4'(10 + $urandom_range(0, 2));
    else if (r == 6) o = allow_halt ? 4'hF : 4'h0;
    else             o = 4'($urandom_range(0, 14));
    return {o, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 6'($urandom)};
  endfunction

  task automatic rand_inputs(input bit allow_halt, input int mem_pct);
    ins_id    = rand_ins(0);
    ins_ex    = rand_ins(allow_halt);
    id_valid  = ($urandom_range(0, 9) != 0);
    ex_valid  = ($urandom_range(0, 9) != 0);
    do_branch = $urandom_range(0, 1) != 0;
    mem_req   = $urandom_range(0, 99) < mem_pct;
    mem_ack   = $urandom_range(0, 1) != 0;
  endtask

  task automatic boot_idle();
    idle_inputs();
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
    for (int i = 0; i < int'(BOOT_CYCLES); i++) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== C_BOOT ||
        {mem_timeout, stall_cnt, flush_cnt} !== 33'd0) begin
      failures++;
      $display("FAIL reset_state ctrl=%b stat=%h expected ctrl=%b stat=0", {pc_we,pc_sel,if_id_we,
               if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}, {mem_timeout, stall_cnt, flush_cnt}, C_BOOT);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < int'(BOOT_CYCLES) + 2; i++) begin
      if (i < int'(BOOT_CYCLES)) rand_inputs(1, 30);
      else idle_inputs();
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl() ||
          pc_we !== (i >= int'(BOOT_CYCLES))) begin
        failures++;
        $display("FAIL boot_cycle%0d ctrl=%b expected %b", i, {pc_we,pc_sel,if_id_we,if_id_flush,
                 id_ex_we,id_ex_flush,ex_mem_we,halted}, exp_ctrl());
      end
      checks++;
      if ({mem_timeout, stall_cnt, flush_cnt} !== exp_stat()) begin
        failures++;
        $display("FAIL boot_stat%0d got=%h expected=%h", i, {mem_timeout, stall_cnt, flush_cnt}, exp_stat());
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    boot_idle();
    for (int i = 0; i < 60; i++) begin
      if (i == 0) begin
        idle_inputs();
        ins_ex = 16'h8240; ex_valid = 1; ins_id = 16'h0250; id_valid = 1;
      end else begin
        rand_inputs(0, 0);
      end
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl()) begin
        failures++;
        $display("FAIL load_use%0d ex=%h id=%h ctrl=%b expected %b", i, ins_ex, ins_id, {pc_we,pc_sel,
                 if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}, exp_ctrl());
      end
      checks++;
      if ({mem_timeout, stall_cnt, flush_cnt} !== exp_stat() || (i == 1 && stall_cnt !== 16'd1)) begin
        failures++;
        $display("FAIL load_use_stat%0d got=%h expected=%h", i, {mem_timeout, stall_cnt, flush_cnt}, exp_stat());
      end
      tick();
    end
  endtask

  task automatic test_branch();
    int f0;
    boot_idle();
    idle_inputs();
    ins_ex = 16'hA005; ex_valid = 1; do_branch = 1; ins_id = 16'h0000; id_valid = 1;
    @(negedge clk);
    checks++;
    if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== C_BRANCH) begin
      failures++;
      $display("FAIL branch_ctrl got=%b expected %b", {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,
               id_ex_flush,ex_mem_we,halted}, C_BRANCH);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL branch_counts flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt);
    end
    f0 = m_flush;
    for (int i = 0; i < 60; i++) begin
      rand_inputs(0, 0);
      do_branch = 1;
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl()) begin
        failures++;
        $display("FAIL branch%0d ex=%h ctrl=%b expected %b", i, ins_ex, {pc_we,pc_sel,if_id_we,
                 if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}, exp_ctrl());
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({mem_timeout, stall_cnt, flush_cnt} !== exp_stat() || m_flush == f0) begin
      failures++;
      $display("FAIL branch_stat got=%h expected=%h", {mem_timeout, stall_cnt, flush_cnt}, exp_stat());
    end
  endtask

  task automatic test_mem_wait();
    boot_idle();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      mem_req = (i < 4);
      mem_ack = (i == 3);
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl() ||
          pc_we !== (i >= 3)) begin
        failures++;
        $display("FAIL mem_wait%0d ctrl=%b expected %b", i, {pc_we,pc_sel,if_id_we,if_id_flush,
                 id_ex_we,id_ex_flush,ex_mem_we,halted}, exp_ctrl());
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd3 || {mem_timeout, stall_cnt, flush_cnt} !== exp_stat()) begin
      failures++;
      $display("FAIL mem_wait_stall got=%0d expected 3", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    boot_idle();
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      mem_req = 1;
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl() ||
          {mem_timeout, stall_cnt, flush_cnt} !== exp_stat()) begin
        failures++;
        $display("FAIL timeout%0d ctrl=%b stat=%h expected ctrl=%b stat=%h", i, {pc_we,pc_sel,if_id_we,
                 if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}, {mem_timeout, stall_cnt, flush_cnt},
                 exp_ctrl(), exp_stat());
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b1 || halted !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky timeout=%b halted=%b expected 1 1", mem_timeout, halted);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (mem_timeout !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear timeout=%b halted=%b expected 0 0", mem_timeout, halted);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_halt();
    boot_idle();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        idle_inputs();
        ins_ex = 16'hF000; ex_valid = 1;
      end else begin
        rand_inputs(1, 20);
      end
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl() ||
          (i > 0 && (halted !== 1'b1 || pc_we !== 1'b0 || ex_mem_we !== 1'b1))) begin
        failures++;
        $display("FAIL halt%0d ctrl=%b expected %b", i, {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,
                 id_ex_flush,ex_mem_we,halted}, exp_ctrl());
      end
      tick();
    end
    rst_n = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== C_BOOT ||
        {mem_timeout, stall_cnt, flush_cnt} !== 33'd0) begin
      failures++;
      $display("FAIL halt_reset ctrl=%b stat=%h expected ctrl=%b stat=0", {pc_we,pc_sel,if_id_we,
               if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted}, {mem_timeout, stall_cnt, flush_cnt}, C_BOOT);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_random();
    int halt_age = 0;
    boot_idle();
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1, 15);
      if (m_mode == "HALT") halt_age++;
      else halt_age = 0;
      rst_n = (halt_age < 4);
      if (!rst_n) model_reset();
      @(negedge clk);
      checks++;
      if ({pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted} !== exp_ctrl() ||
          {mem_timeout, stall_cnt, flush_cnt} !== exp_stat()) begin
        failures++;
        $display("FAIL random%0d ex=%h id=%h ctrl=%b stat=%h expected ctrl=%b stat=%h", i, ins_ex, ins_id,
                 {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,halted},
                 {mem_timeout, stall_cnt, flush_cnt}, exp_ctrl(), exp_stat());
      end
      tick();
      if (!rst_n) halt_age = 0;
      rst_n = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
